// File: rtl/ring_alert_pkg.sv
// Shared types and width helpers for the phone-alert controller.
package ring_alert_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  // Index width for n sources; a single source still needs one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ring_alert_ctrl_prio_pick.sv
// Fixed-priority picker: lowest set request index wins, reported encoded.
module prio_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [N-1:0] grant;

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    if (gi == 0) begin : g_first
      assign grant[gi] = req[gi];
    end else begin : g_rest
      assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
    end
  end

  // grant is one-hot, so OR-ing the indices yields the winner's index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) idx = idx | W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/ring_alert_ctrl.sv
// Incoming-call alert controller: arbitrates call sources and drives the
// ringer or motor in an ON/OFF cadence until answer, hang-up or timeout.
module ring_alert_ctrl
  import ring_alert_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int ON_CYC     = 4,
  parameter int OFF_CYC    = 2,
  parameter int MAX_BURSTS = 3,
  localparam int SRC_W     = src_w(N_SRC)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [N_SRC-1:0] ring,
  input  logic             vibrate_mode,
  input  logic             silent_mode,
  input  logic             ack,
  output logic             ringer,
  output logic             motor,
  output logic             busy,
  output logic [SRC_W-1:0] active_src,
  output logic             missed
);

  localparam int PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BU_W   = $clog2(MAX_BURSTS + 1);
  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_CYC - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_CYC - 1);
  localparam logic [BU_W-1:0] BU_LAST  = BU_W'(MAX_BURSTS - 1);

  state_e             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BU_W-1:0]    burst_q, burst_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               missed_q, missed_d;

  logic [N_SRC-1:0]   src_sel;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               hangup;
  logic               timeout;
  logic               mask_set;

  prio_pick #(.N(N_SRC), .W(SRC_W)) u_pick (
    .req   (ring & ~mask_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_sel
    assign src_sel[gi] = (src_q == SRC_W'(gi));
  end

  assign hangup = ~(|(ring & src_sel));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    burst_d  = burst_q;
    src_d    = src_q;
    missed_d = 1'b0;
    timeout  = 1'b0;
    mask_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ON;
          phase_d = '0;
          burst_d = '0;
          src_d   = pick_idx;
        end
      end
      ON: begin
        if (phase_q == ON_LAST) begin
          state_d = OFF;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      OFF: begin
        if (phase_q == OFF_LAST) begin
          burst_d = burst_q + BU_W'(1);
          phase_d = '0;
          if (burst_q == BU_LAST) begin
            state_d = IDLE;
            timeout = 1'b1;
          end else begin
            state_d = ON;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Answer beats hang-up beats timeout; a hang-up coinciding with timeout
    // still masks the source so it is not immediately re-alerted.
    if (state_q != IDLE) begin
      if (ack) begin
        state_d = IDLE;
      end else if (hangup) begin
        state_d  = IDLE;
        missed_d = 1'b1;
        mask_set = timeout;
      end else if (timeout) begin
        missed_d = 1'b1;
        mask_set = 1'b1;
      end
    end

    mask_d = (mask_q & ring) | (src_sel & {N_SRC{mask_set}});
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      burst_q  <= '0;
      mask_q   <= '0;
      src_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      burst_q  <= burst_d;
      mask_q   <= mask_d;
      src_q    <= src_d;
      missed_q <= missed_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign ringer     = (state_q == ON) & ~vibrate_mode & ~silent_mode;
  assign motor      = (state_q == ON) &  vibrate_mode & ~silent_mode;
  assign active_src = src_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_ring_alert_ctrl.sv
// Directed bench for ring_alert_ctrl: a timeline model of the alert is
// checked every cycle, plus literal checks on both parameter sets.
module tb_ring_alert_ctrl;

  localparam int N    = 4;
  localparam int ON_C = 4;
  localparam int OFFC = 2;
  localparam int MAXB = 3;
  localparam int PER  = ON_C + OFFC;
  localparam int TOT  = MAXB * PER;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic [3:0] ring = '0;
  logic       vib = 1'b0;
  logic       sil = 1'b0;
  logic       ack = 1'b0;
  logic       ringer, motor, busy, missed;
  logic [1:0] active_src;

  logic [0:0] ring_s = '0;
  logic       ringer_s, motor_s, busy_s, missed_s;
  logic [0:0] active_src_s;

  int total = 0;
  int bad   = 0;

  ring_alert_ctrl #(.N_SRC(N), .ON_CYC(ON_C), .OFF_CYC(OFFC), .MAX_BURSTS(MAXB)) dut (
    .clk(clk), .areset(areset), .ring(ring), .vibrate_mode(vib),
    .silent_mode(sil), .ack(ack), .ringer(ringer), .motor(motor),
    .busy(busy), .active_src(active_src), .missed(missed)
  );

  ring_alert_ctrl #(.N_SRC(1), .ON_CYC(1), .OFF_CYC(1), .MAX_BURSTS(1)) dut_s (
    .clk(clk), .areset(areset), .ring(ring_s), .vibrate_mode(1'b0),
    .silent_mode(1'b0), .ack(1'b0), .ringer(ringer_s), .motor(motor_s),
    .busy(busy_s), .active_src(active_src_s), .missed(missed_s)
  );

  always #5 clk = ~clk;

  // Model: an alert is a timeline t = 0..TOT-1; ON when t mod PER < ON_C.
  bit         m_busy = 0;
  int         m_t = 0;
  int         m_src = 0;
  logic [3:0] m_mask = '0;
  bit         m_missed = 0;

  bit         n_busy;
  int         n_t;
  int         n_src;
  logic [3:0] n_mask;
  bit         n_missed;

  always_comb begin
    n_busy   = m_busy;
    n_t      = m_t;
    n_src    = m_src;
    n_mask   = m_mask & ring;
    n_missed = 0;
    if (!m_busy) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (ring[i] && !m_mask[i]) begin
          n_busy = 1;
          n_src  = i;
          n_t    = 0;
        end
      end
    end else if (ack) begin
      n_busy = 0;
    end else if (!ring[m_src] || m_t == TOT - 1) begin
      n_busy   = 0;
      n_missed = 1;
      if (m_t == TOT - 1) n_mask[m_src] = 1'b1;
    end else begin
      n_t = m_t + 1;
    end
  end

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      m_busy   <= 0;
      m_t      <= 0;
      m_src    <= 0;
      m_mask   <= '0;
      m_missed <= 0;
    end else begin
      m_busy   <= n_busy;
      m_t      <= n_t;
      m_src    <= n_src;
      m_mask   <= n_mask;
      m_missed <= n_missed;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit on;
    on = m_busy && ((m_t % PER) < ON_C);
    check("model.ringer", int'(ringer), int'(on && !vib && !sil));
    check("model.motor", int'(motor), int'(on && vib && !sil));
    check("model.busy", int'(busy), int'(m_busy));
    check("model.active_src", int'(active_src), m_src);
    check("model.missed", int'(missed), int'(m_missed));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_count(input int n, output int b, output int r, output int mo, output int mi);
    b = 0; r = 0; mo = 0; mi = 0;
    repeat (n) begin
      tick();
      b  += int'(busy);
      r  += int'(ringer);
      mo += int'(motor);
      mi += int'(missed);
    end
  endtask

  int cb, cr, cm, cmi;

  initial begin
    #1 areset = 1'b1;
    #1;
    check("reset.busy", int'(busy), 0);
    check("reset.ringer", int'(ringer), 0);
    check("reset.missed", int'(missed), 0);
    check("reset.active_src", int'(active_src), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) areset = 1'b0;
    #2;

    $display("step 1: single source timeout");
    ring = 4'b0010;
    tick();
    check("t1.active_src", int'(active_src), 1);
    check("t1.first_ringer", int'(ringer), 1);
    run_count(19, cb, cr, cm, cmi);
    check("t1.busy_cycles", cb + 1, 18);
    check("t1.ringer_cycles", cr + 1, 12);
    check("t1.missed_pulses", cmi, 1);
    repeat (5) tick();
    check("t1.no_realert", int'(busy), 0);
    ring = 4'b0000;
    tick();
    ring = 4'b0010;
    tick();
    check("t1.realert_busy", int'(busy), 1);
    ring = 4'b0000;
    tick();
    check("t1.hangup_missed", int'(missed), 1);
    tick();

    $display("step 2: priority and hang-up");
    ring = 4'b1100;
    tick();
    check("t2.active_src", int'(active_src), 2);
    tick();
    ring = 4'b1000;
    tick();
    check("t2.hangup_busy", int'(busy), 0);
    check("t2.hangup_missed", int'(missed), 1);
    tick();
    check("t2.next_busy", int'(busy), 1);
    check("t2.next_src", int'(active_src), 3);
    ring = 4'b0000;
    repeat (3) tick();

    $display("step 3: answer mid-ON and on final OFF");
    ring = 4'b0001;
    repeat (3) tick();
    ack = 1'b1;
    tick();
    check("t3.ack_busy", int'(busy), 0);
    check("t3.ack_ringer", int'(ringer), 0);
    check("t3.ack_missed", int'(missed), 0);
    ack = 1'b0;
    tick();
    repeat (17) tick();
    ack = 1'b1;
    tick();
    check("t3.lastoff_busy", int'(busy), 0);
    check("t3.lastoff_missed", int'(missed), 0);
    ack = 1'b0;
    ring = 4'b0000;
    tick();
    check("t3.lastoff_missed2", int'(missed), 0);
    tick();

    $display("step 4: vibrate toggle and silent alert");
    ring = 4'b0100;
    tick();
    check("t4.ringer", int'(ringer), 1);
    vib = 1'b1;
    #1;
    check("t4.vib_ringer", int'(ringer), 0);
    check("t4.vib_motor", int'(motor), 1);
    vib = 1'b0;
    #1;
    check("t4.unvib_ringer", int'(ringer), 1);
    sil = 1'b1;
    run_count(19, cb, cr, cm, cmi);
    check("t4.silent_busy_cycles", cb + 1, 18);
    check("t4.silent_drive", cr + cm, 0);
    check("t4.silent_missed", cmi, 1);
    sil = 1'b0;
    repeat (3) tick();
    check("t4.masked_idle", int'(busy), 0);

    $display("step 5: async reset mid-OFF");
    ring = 4'b0110;
    tick();
    check("t5.src_skips_masked", int'(active_src), 1);
    repeat (4) tick();
    #1 areset = 1'b1;
    #1;
    check("t5.rst_busy", int'(busy), 0);
    check("t5.rst_ringer", int'(ringer), 0);
    check("t5.rst_motor", int'(motor), 0);
    check("t5.rst_src", int'(active_src), 0);
    ring = 4'b0100;
    @(negedge clk) areset = 1'b0;
    tick();
    check("t5.mask_cleared_src", int'(active_src), 2);
    check("t5.fresh_busy", int'(busy), 1);
    run_count(19, cb, cr, cm, cmi);
    check("t5.busy_cycles", cb + 1, 18);
    check("t5.missed", cmi, 1);
    ring = 4'b0000;
    repeat (2) tick();

    $display("step 6: minimal configuration");
    ring_s = 1'b1;
    tick();
    check("t6.ringer", int'(ringer_s), 1);
    check("t6.busy", int'(busy_s), 1);
    check("t6.src", int'(active_src_s), 0);
    tick();
    check("t6.off_ringer", int'(ringer_s), 0);
    check("t6.off_busy", int'(busy_s), 1);
    tick();
    check("t6.missed", int'(missed_s), 1);
    check("t6.idle", int'(busy_s), 0);
    tick();
    check("t6.missed_end", int'(missed_s), 0);
    check("t6.masked", int'(busy_s), 0);
    check("t6.motor", int'(motor_s), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ring_alert_ctrl.md
Name: ring_alert_ctrl

Overview:
Parametrised phone-alert controller, the successor to the combinational ringer/motor gating block.
- Arbitrates N_SRC incoming-call request lines.
- Drives the ringer or motor in an ON/OFF cadence, gated by live vibrate/silent modes.
- Ends the alert on user answer, caller hang-up or burst timeout, and flags missed calls.
- Sits between the call-signalling logic and the ringer/motor drivers.

Parameters:
- N_SRC, 4: number of request lines; index 0 has highest priority.
- ON_CYC, 4: cycles per ON phase (>=1).
- OFF_CYC, 2: cycles per OFF phase (>=1).
- MAX_BURSTS, 3: ON+OFF bursts before timeout (>=1).

Ports:
- clk  in  1  clock
- areset  in  1  asynchronous active-high reset
- ring  in  N_SRC  per-source call request, level
- vibrate_mode  in  1  1 = motor instead of ringer
- silent_mode  in  1  1 = suppress both ringer and motor; timing unaffected
- ack  in  1  user answered, level sampled each cycle
- ringer  out  1  ringer drive
- motor  out  1  motor drive
- busy  out  1  alert in progress
- active_src  out  SRC_W = max(1,$clog2(N_SRC))  index of source being alerted
- missed  out  1  one-cycle pulse, call ended unanswered

Behaviour:
- Clock and reset: one clock, clk. Reset areset is asynchronous and active-high.
- Reset values: state IDLE; phase counter 0; burst counter 0; mask all 0; active_src 0; missed 0; ringer, motor, busy 0.
- Counters: phase counter width $clog2(max(ON_CYC,OFF_CYC)+1); burst counter width $clog2(MAX_BURSTS+1); no wrap reachable.
- Eligible set: ring & ~mask. Winner = lowest eligible index.
- States: IDLE, ON, OFF.
- IDLE:
  - If any source is eligible at a posedge: latch winner into active_src, go ON, phase=0, burst=0.
  - Latency from ring high to ringer/motor high is 1 cycle.
  - ack in IDLE is ignored.
- ON: stays ON_CYC cycles, then OFF with phase=0.
- OFF:
  - Stays OFF_CYC cycles.
  - At its end, burst++.
  - If burst reaches MAX_BURSTS: go IDLE, missed=1 next cycle, mask[active_src]=1 (timeout).
  - Otherwise go ON.
- Termination, evaluated every ON/OFF cycle with priority ack > hang-up > timeout:
  - ack=1: next state IDLE, no missed, no mask.
  - ring[active_src]=0 (hang-up): next state IDLE, missed pulses 1 cycle, no mask.
- Simultaneous events: ack and timeout in the same cycle gives ack semantics. Hang-up and timeout in the same cycle gives a single missed pulse, and mask is still set.
- Mask: mask[i] clears when ring[i]=0 at a posedge. A masked source with ring held high is never re-alerted.
- Preemption: none. A higher-priority source arriving mid-alert waits until IDLE. Back-to-back alerts are allowed: IDLE lasts at least 1 cycle.
- Outputs, combinational from state register plus live modes:
  - on = (state==ON)
  - ringer = on & ~vibrate_mode & ~silent_mode
  - motor = on & vibrate_mode & ~silent_mode
  - busy = (state!=IDLE)
  - Mode changes take effect in the same cycle.
- active_src holds its last value in IDLE.
- missed is registered, exactly one cycle wide.
- areset mid-alert: outputs 0 immediately; mask cleared.

Decomposition:
- Package ring_alert_pkg holds the state enum (IDLE/ON/OFF) and the SRC_W width function.
- Sub-module prio_pick (lowest-index one-hot/encoded picker over N_SRC) is natural and reusable.
- Cadence counters and FSM stay in the top module.

Test Plan:
- Default parameters, ring=4'b0010, vib=0, no ack:
  - active_src=1.
  - ringer pattern 4 high / 2 low repeated ×3 (18 cycles of busy), starting 1 cycle after ring.
  - missed pulses once, then busy=0.
  - With ring held, there is no re-alert until ring[1] drops and rises again.
- ring=4'b1100 simultaneously → active_src=2. Drop ring[2] mid-ON → IDLE next cycle with a missed pulse. Next cycle after IDLE, alert restarts with active_src=3.
- ack asserted on the 3rd ON cycle → ringer drops next cycle, busy=0, missed stays 0. ack on the final OFF cycle → no missed.
- Toggle vibrate_mode mid-ON → ringer/motor swap in the same cycle. silent_mode=1 whole alert → ringer=motor=0, busy and timeout timing unchanged, missed still pulses.
- areset asserted asynchronously mid-OFF → all outputs 0 without a clock edge. After release with ring still high → fresh alert, burst count restarted (full 18-cycle timeout).
- N_SRC=1, ON_CYC=1, OFF_CYC=1, MAX_BURSTS=1: ringer high exactly 1 cycle, missed 2 cycles after the alert starts. SRC_W=1, active_src=0.
